// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_arbiter
// Brief    : Two-master round-robin arbiter in front of a single-port on-chip
//            RAM with one-cycle read latency and a sticky out-of-range flag.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4,
    parameter int DEPTH  = 5120
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              mem_clken,

    output logic              range_err,
    input  logic              range_err_clr
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

    logic              r_prio;      // 0: m0 wins a contested cycle, 1: m1 wins
    logic              r_rd_valid;
    logic              r_rd_tag;
    logic              r_rd_oor;
    logic              r_range_err;

    logic              w_m0_req;
    logic              w_m1_req;
    logic              w_gnt1;
    logic              w_acc;
    logic              w_is_wr;
    logic              w_in_range;
    logic              w_rd0;
    logic              w_rd1;
    logic              w_err_set;
    logic [ADDR_W-1:0] w_addr;

    always_comb begin
        w_m0_req   = m0_read | m0_write;
        w_m1_req   = m1_read | m1_write;
        // Nothing is accepted while reset is held.
        w_acc      = (w_m0_req | w_m1_req) & ~reset;
        w_gnt1     = w_m1_req & (~w_m0_req | r_prio);
        // A combined read+write request is handled as a write.
        w_is_wr    = w_gnt1 ? m1_write : m0_write;
        w_addr     = w_gnt1 ? m1_address : m0_address;
        w_in_range = {1'b0, w_addr} < C_DEPTH;
    end

    assign m0_waitrequest = ~(w_acc & ~w_gnt1);
    assign m1_waitrequest = ~(w_acc &  w_gnt1);

    assign mem_address    = w_addr;
    assign mem_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = w_acc;
    assign mem_write      = w_acc & w_is_wr & w_in_range;
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_tag   <= 1'b0;
            r_rd_oor   <= 1'b0;
        end else begin
            if (w_acc && w_m0_req && w_m1_req)
                r_prio <= ~r_prio;
            r_rd_valid <= w_acc & ~w_is_wr;
            r_rd_tag   <= w_gnt1;
            r_rd_oor   <= ~w_in_range;
        end
    end

    // A read launched just before reset must not surface while reset is high.
    assign w_rd0 = r_rd_valid & ~r_rd_tag & ~reset;
    assign w_rd1 = r_rd_valid &  r_rd_tag & ~reset;

    assign m0_readdatavalid = w_rd0;
    assign m1_readdatavalid = w_rd1;
    assign m0_readdata      = (w_rd0 && !r_rd_oor) ? mem_readdata : '0;
    assign m1_readdata      = (w_rd1 && !r_rd_oor) ? mem_readdata : '0;

    // Writes flag on acceptance, reads flag when their (zeroed) data returns.
    assign w_err_set = (w_acc & w_is_wr & ~w_in_range) | (r_rd_valid & r_rd_oor);

    always_ff @(posedge clk) begin
        if (reset)
            r_range_err <= 1'b0;
        else if (w_err_set)
            r_range_err <= 1'b1;
        else if (range_err_clr)
            r_range_err <= 1'b0;
    end

    assign range_err = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_mem_arbiter
// Brief    : Directed self-checking bench for onchip_mem_arbiter with a
//            behavioural one-cycle-latency RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        range_err, range_err_clr;

    int total = 0;
    int bad   = 0;
    int cnt0, cnt1;

    logic [31:0] ram [0:5119];

    always #5 clk = ~clk;

    onchip_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_readdata     (mem_readdata),
        .mem_clken        (mem_clken),
        .range_err        (range_err),
        .range_err_clr    (range_err_clr)
    );

    // Single-port RAM: registered read, byte-lane writes.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_address < 13'd5120) begin
                mem_readdata <= ram[mem_address];
                if (mem_write)
                    for (int b = 0; b < 4; b++)
                        if (mem_byteenable[b])
                            ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= 32'hBAD0BAD0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    endtask

    task automatic m0_wr(input logic [12:0] a, input logic [31:0] d);
        m0_address = a; m0_writedata = d; m0_write = 1; m0_read = 0;
    endtask

    task automatic m0_rd(input logic [12:0] a);
        m0_address = a; m0_read = 1; m0_write = 0;
    endtask

    initial begin
        idle();
        m0_address = 0; m1_address = 0; m0_writedata = 0; m1_writedata = 0;
        range_err_clr = 0;
        reset = 1;
        m0_read = 1;
        cyc(); cyc();
        chk("rst_wait0", {31'b0, m0_waitrequest}, 1);
        chk("rst_wait1", {31'b0, m1_waitrequest}, 1);
        chk("rst_rdv0", {31'b0, m0_readdatavalid}, 0);
        chk("rst_cs", {31'b0, mem_chipselect}, 0);
        chk("rst_memwr", {31'b0, mem_write}, 0);
        chk("rst_clken", {31'b0, mem_clken}, 1);
        chk("rst_err", {31'b0, range_err}, 0);
        idle();
        reset = 0;
        cyc();

        // Write then read back on m0
        m0_wr(13'h0010, 32'hDEADBEEF);
        #1;
        chk("wr_wait0", {31'b0, m0_waitrequest}, 0);
        chk("wr_memwr", {31'b0, mem_write}, 1);
        cyc();
        m0_rd(13'h0010);
        #1;
        chk("rd_wait0", {31'b0, m0_waitrequest}, 0);
        chk("rd_memwr", {31'b0, mem_write}, 0);
        cyc();
        idle();
        chk("rd_rdv0", {31'b0, m0_readdatavalid}, 1);
        chk("rd_data0", m0_readdata, 32'hDEADBEEF);
        chk("rd_rdv1", {31'b0, m1_readdatavalid}, 0);
        chk("rd_data1", m1_readdata, 0);
        cyc();

        // m1 write, then contested reads alternate starting from m0
        m1_address = 13'h0011; m1_writedata = 32'hCAFEF00D; m1_write = 1;
        cyc();
        idle();
        reset = 1; cyc(); reset = 0;
        m0_rd(13'h0010);
        m1_address = 13'h0011; m1_read = 1;
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("alt_wait0_%0d", k), {31'b0, m0_waitrequest}, (k % 2 == 0) ? 0 : 1);
            chk($sformatf("alt_wait1_%0d", k), {31'b0, m1_waitrequest}, (k % 2 == 0) ? 1 : 0);
            if (k > 0) begin
                chk($sformatf("alt_rdv0_%0d", k), {31'b0, m0_readdatavalid}, (k % 2 == 1) ? 1 : 0);
                chk($sformatf("alt_rdv1_%0d", k), {31'b0, m1_readdatavalid}, (k % 2 == 0) ? 1 : 0);
                if (k % 2 == 1) chk("alt_d0", m0_readdata, 32'hDEADBEEF);
                else            chk("alt_d1", m1_readdata, 32'hCAFEF00D);
            end
            cnt0 += int'(m0_readdatavalid);
            cnt1 += int'(m1_readdatavalid);
            cyc();
        end
        idle();
        chk("alt_rdv1_last", {31'b0, m1_readdatavalid}, 1);
        chk("alt_d1_last", m1_readdata, 32'hCAFEF00D);
        cnt0 += int'(m0_readdatavalid);
        cnt1 += int'(m1_readdatavalid);
        chk("alt_cnt0", cnt0, 3);
        chk("alt_cnt1", cnt1, 3);
        cyc();

        // Partial byte-lane write from m1
        m0_wr(13'h0020, 32'h11223344);
        cyc();
        idle();
        m1_address = 13'h0020; m1_byteenable = 4'b0010; m1_writedata = 32'h0000AB00; m1_write = 1;
        cyc();
        m1_write = 0; m1_byteenable = 4'hF; m1_read = 1;
        cyc();
        idle();
        chk("be_rdv1", {31'b0, m1_readdatavalid}, 1);
        chk("be_data", m1_readdata, 32'h1122AB44);

        // Last populated word is in range
        m0_wr(13'd5119, 32'h0BADCAFE);
        #1;
        chk("edge_memwr", {31'b0, mem_write}, 1);
        cyc();
        idle();
        chk("edge_err", {31'b0, range_err}, 0);

        // Out-of-range write and read
        m0_wr(13'h1400, 32'h12345678);
        #1;
        chk("oor_wait0", {31'b0, m0_waitrequest}, 0);
        chk("oor_memwr", {31'b0, mem_write}, 0);
        chk("oor_cs", {31'b0, mem_chipselect}, 1);
        cyc();
        chk("oor_err_w", {31'b0, range_err}, 1);
        m0_rd(13'h1400);
        cyc();
        idle();
        chk("oor_rdv0", {31'b0, m0_readdatavalid}, 1);
        chk("oor_data0", m0_readdata, 0);
        cyc();
        chk("oor_err_hold", {31'b0, range_err}, 1);
        range_err_clr = 1;
        cyc();
        range_err_clr = 0;
        chk("oor_err_clr", {31'b0, range_err}, 0);
        m0_wr(13'h1FFF, 32'h0);
        range_err_clr = 1;
        cyc();
        idle();
        range_err_clr = 0;
        chk("oor_set_prio", {31'b0, range_err}, 1);
        range_err_clr = 1; cyc(); range_err_clr = 0;

        // Reset while a read is in flight; prio left at m1 beforehand
        m0_rd(13'h0010);
        m1_address = 13'h0011; m1_read = 1;
        #1;
        chk("rr_wait0", {31'b0, m0_waitrequest}, 0);
        cyc();
        idle();
        reset = 1;
        #1;
        chk("rr_rdv_in", {31'b0, m0_readdatavalid}, 0);
        cyc();
        reset = 0;
        chk("rr_rdv_rst", {31'b0, m0_readdatavalid}, 0);
        cyc();
        chk("rr_rdv_after", {31'b0, m0_readdatavalid}, 0);
        chk("rr_wait0_idle", {31'b0, m0_waitrequest}, 1);
        chk("rr_wait1_idle", {31'b0, m1_waitrequest}, 1);
        m0_rd(13'h0010);
        m1_read = 1;
        #1;
        chk("rr_prio_w0", {31'b0, m0_waitrequest}, 0);
        chk("rr_prio_w1", {31'b0, m1_waitrequest}, 1);
        cyc();
        idle();
        cyc();

        // Combined read+write is a write
        m0_address = 13'h0005; m0_writedata = 32'hA5A5A5A5; m0_read = 1; m0_write = 1;
        #1;
        chk("rw_memwr", {31'b0, mem_write}, 1);
        cyc();
        idle();
        chk("rw_rdv0", {31'b0, m0_readdatavalid}, 0);
        m0_rd(13'h0005);
        cyc();
        idle();
        chk("rw_rdv0_rd", {31'b0, m0_readdatavalid}, 1);
        chk("rw_data", m0_readdata, 32'hA5A5A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
